// File: rtl/writeback_unit_pkg.sv
// Shared types and defaults for the writeback stage: source select, load
// types (funct3 encoding) and datapath width defaults.
package writeback_unit_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  // WB_IMM was added after the original four; earlier encodings are kept.
  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_MEM  = 3'd1,
    WB_PC4  = 3'd2,
    WB_NONE = 3'd3,
    WB_IMM  = 3'd4
  } wb_sel_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_type_e;

endpackage

// File: rtl/writeback_unit_load_extender.sv
// Combinational sub-word load alignment and sign/zero extension.
// Misaligned halves/words use the lane at the offset; the top bits fall off.
module load_extender
  import writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            offset,
  input  load_type_e            load_type,
  output logic [DATA_WIDTH-1:0] ext_data
);

  localparam logic [2:0] OFF_MASK = (DATA_WIDTH == 64) ? 3'b111 : 3'b011;

  logic [2:0]            lane;
  logic [DATA_WIDTH-1:0] shifted;

  assign lane    = offset & OFF_MASK;
  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    ext_data = shifted;
    case (load_type)
      LB:      ext_data = DATA_WIDTH'($signed(shifted[7:0]));
      LH:      ext_data = DATA_WIDTH'($signed(shifted[15:0]));
      LW:      ext_data = DATA_WIDTH'($signed(shifted[31:0]));
      LBU:     ext_data = DATA_WIDTH'(shifted[7:0]);
      LHU:     ext_data = DATA_WIDTH'(shifted[15:0]);
      LWU:     ext_data = DATA_WIDTH'(shifted[31:0]);
      default: ext_data = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Registered writeback stage: source select, load extraction, RF write port.
// Non-mem results land one edge after accept; loads hold ready low until rvalid, flush or timeout.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      WB_valid_i,
  output logic                      WB_ready_o,
  input  wb_sel_e                   WB_WBSel_i,
  input  logic                      WB_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] WB_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     WB_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     WB_pc_plus4_i,
  input  logic [DATA_WIDTH-1:0]     WB_imm_i,
  input  load_type_e                WB_load_type_i,
  input  logic                      WB_mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     WB_mem_rdata_i,
  input  logic                      WB_flush_i,
  output logic                      WB_rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] WB_rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     WB_writeback_data_o,
  output logic                      WB_stall_o,
  output logic                      WB_timeout_err_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] cap_rd;
  logic                      cap_we;
  wb_sel_e                   cap_sel;
  load_type_e                cap_lt;
  logic [2:0]                cap_off;

  logic                      accept, complete, timeout_hit;
  wb_sel_e                   sel_use;
  logic                      we_use;
  logic [REG_ADDR_WIDTH-1:0] rd_use;
  logic [2:0]                off_use;
  load_type_e                lt_use;
  logic [DATA_WIDTH-1:0]     ext_data, wb_data;

  assign WB_ready_o  = (state_q == IDLE);
  assign WB_stall_o  = ~WB_ready_o;
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // In IDLE a completing instruction comes straight from the ports; in WAIT_MEM from the capture.
  always_comb begin
    sel_use = WB_WBSel_i;
    we_use  = WB_reg_write_i;
    rd_use  = WB_rd_addr_i;
    off_use = WB_alu_result_i[2:0];
    lt_use  = WB_load_type_i;
    if (state_q == WAIT_MEM) begin
      sel_use = cap_sel;
      we_use  = cap_we;
      rd_use  = cap_rd;
      off_use = cap_off;
      lt_use  = cap_lt;
    end
  end

  load_extender #(.DATA_WIDTH(DATA_WIDTH)) u_load_extender (
    .rdata     (WB_mem_rdata_i),
    .offset    (off_use),
    .load_type (lt_use),
    .ext_data  (ext_data)
  );

  always_comb begin
    wb_data = '0;
    case (sel_use)
      WB_ALU:  wb_data = WB_alu_result_i;
      WB_MEM:  wb_data = ext_data;
      WB_PC4:  wb_data = WB_pc_plus4_i;
      WB_IMM:  wb_data = WB_imm_i;
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (WB_valid_i && !WB_flush_i) begin
          accept = 1'b1;
          if (WB_WBSel_i != WB_MEM || WB_mem_rvalid_i) complete = 1'b1;
          else                                        state_d  = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (WB_flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (WB_mem_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      cap_rd              <= '0;
      cap_we              <= 1'b0;
      cap_sel             <= WB_ALU;
      cap_lt              <= LB;
      cap_off             <= '0;
      WB_rf_we_o          <= 1'b0;
      WB_rf_waddr_o       <= '0;
      WB_writeback_data_o <= '0;
      WB_timeout_err_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      WB_rf_we_o <= 1'b0;
      if (accept) begin
        cap_rd  <= WB_rd_addr_i;
        cap_we  <= WB_reg_write_i;
        cap_sel <= WB_WBSel_i;
        cap_lt  <= WB_load_type_i;
        cap_off <= WB_alu_result_i[2:0];
      end
      if (complete) begin
        WB_rf_we_o          <= we_use && (rd_use != '0) && (sel_use != WB_NONE);
        WB_rf_waddr_o       <= rd_use;
        WB_writeback_data_o <= wb_data;
      end
      if (state_q == WAIT_MEM && !WB_flush_i && !WB_mem_rvalid_i && timeout_hit)
        WB_timeout_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed plus randomized bench for writeback_unit against a transaction-level reference.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic        clk, rst;
  logic        valid, ready, reg_write, rvalid, flush;
  wb_sel_e     sel;
  logic [4:0]  rd;
  logic [31:0] alu, pc4, imm, rdata;
  load_type_e  lt;
  logic        rf_we, stall, terr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int compared = 0;
  int mismatched = 0;

  // Reference state: one outstanding load at most.
  logic        m_busy, m_rw, m_err;
  logic [4:0]  m_rd;
  logic [1:0]  m_off;
  load_type_e  m_lt;
  int          m_cnt;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .WB_valid_i(valid), .WB_ready_o(ready), .WB_WBSel_i(sel),
    .WB_reg_write_i(reg_write), .WB_rd_addr_i(rd), .WB_alu_result_i(alu),
    .WB_pc_plus4_i(pc4), .WB_imm_i(imm), .WB_load_type_i(lt),
    .WB_mem_rvalid_i(rvalid), .WB_mem_rdata_i(rdata), .WB_flush_i(flush),
    .WB_rf_we_o(rf_we), .WB_rf_waddr_o(waddr), .WB_writeback_data_o(wdata),
    .WB_stall_o(stall), .WB_timeout_err_o(terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input load_type_e t);
    logic [31:0] s;
    s = w >> (8 * off);
    case (t)
      LB:      return s[7]  ? ((s & 32'hFF)   | 32'hFFFF_FF00) : (s & 32'hFF);
      LH:      return s[15] ? ((s & 32'hFFFF) | 32'hFFFF_0000) : (s & 32'hFFFF);
      LBU:     return s & 32'hFF;
      LHU:     return s & 32'hFFFF;
      default: return s;
    endcase
  endfunction

  task automatic step(input logic v, input wb_sel_e s, input logic rw, input logic [4:0] r,
                      input logic [31:0] a, input logic [31:0] p, input logic [31:0] im,
                      input load_type_e t, input logic rv, input logic [31:0] rd_w,
                      input logic fl);
    logic        done, e_rw;
    logic [4:0]  e_rd;
    wb_sel_e     e_sel;
    logic [31:0] e_data;
    valid = v; sel = s; reg_write = rw; rd = r; alu = a; pc4 = p; imm = im;
    lt = t; rvalid = rv; rdata = rd_w; flush = fl;
    done = 1'b0; e_rw = 1'b0; e_rd = '0; e_sel = WB_NONE; e_data = '0;
    if (!m_busy) begin
      if (v && !fl) begin
        if (s == WB_MEM && !rv) begin
          m_busy = 1'b1; m_cnt = 0; m_rd = r; m_rw = rw; m_lt = t; m_off = a[1:0];
        end else begin
          done = 1'b1; e_rd = r; e_rw = rw; e_sel = s;
          case (s)
            WB_ALU:  e_data = a;
            WB_PC4:  e_data = p;
            WB_IMM:  e_data = im;
            WB_MEM:  e_data = ref_load(rd_w, a[1:0], t);
            default: e_data = '0;
          endcase
        end
      end
    end else if (fl) begin
      m_busy = 1'b0;
    end else if (rv) begin
      done = 1'b1; e_rd = m_rd; e_rw = m_rw; e_sel = WB_MEM;
      e_data = ref_load(rd_w, m_off, m_lt);
      m_busy = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt == 16) begin
        m_err = 1'b1;
        m_busy = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("rf_we", 32'(rf_we), 32'(done && e_rw && e_rd != 0 && e_sel != WB_NONE));
    chk("ready", 32'(ready), 32'(!m_busy));
    chk("stall", 32'(stall), 32'(m_busy));
    chk("timeout_err", 32'(terr), 32'(m_err));
    if (done) begin
      chk("waddr", 32'(waddr), 32'(e_rd));
      chk("wdata", wdata, e_data);
    end
  endtask

  task automatic idle(input logic rv, input logic [31:0] rd_w, input logic fl);
    step(1'b0, WB_NONE, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, LW, rv, rd_w, fl);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 1'b0; m_err = 1'b0; m_cnt = 0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_err", 32'(terr), 32'd0);
  endtask

  wb_sel_e    sels[5]  = '{WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_NONE};
  load_type_e loads[5] = '{LB, LH, LW, LBU, LHU};

  initial begin
    rst = 1'b1; valid = 1'b0; sel = WB_NONE; reg_write = 1'b0; rd = '0;
    alu = '0; pc4 = '0; imm = '0; lt = LW; rvalid = 1'b0; rdata = '0; flush = 1'b0;
    m_busy = 1'b0; m_err = 1'b0; m_cnt = 0; m_rd = '0; m_rw = 1'b0; m_off = '0; m_lt = LW;
    @(posedge clk); #1;
    do_reset();

    // ALU write lasts exactly one cycle
    step(1'b1, WB_ALU, 1'b1, 5'd5, 32'h1234_5678, 32'd0, 32'd0, LW, 1'b0, 32'd0, 1'b0);
    chk("alu_data", wdata, 32'h1234_5678);
    idle(1'b0, 32'd0, 1'b0);
    chk("alu_we_drop", 32'(rf_we), 32'd0);

    // LB / LBU at offset 3 with rvalid three cycles after accept
    step(1'b1, WB_MEM, 1'b1, 5'd9, 32'd3, 32'd0, 32'd0, LB, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    idle(1'b1, 32'h80FF_0000, 1'b0);
    chk("lb_data", wdata, 32'hFFFF_FF80);
    step(1'b1, WB_MEM, 1'b1, 5'd9, 32'd3, 32'd0, 32'd0, LBU, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    idle(1'b1, 32'h80FF_0000, 1'b0);
    chk("lbu_data", wdata, 32'h0000_0080);

    // LHU with rvalid in the accept cycle: no stall
    step(1'b1, WB_MEM, 1'b1, 5'd3, 32'd2, 32'd0, 32'd0, LHU, 1'b1, 32'hBEEF_1234, 1'b0);
    chk("lhu_data", wdata, 32'h0000_BEEF);
    chk("lhu_nostall", 32'(ready), 32'd1);

    // rd=0 suppresses the write; NONE writes nothing and drives zero
    step(1'b1, WB_PC4, 1'b1, 5'd0, 32'd0, 32'h104, 32'd0, LW, 1'b0, 32'd0, 1'b0);
    chk("pc4_data", wdata, 32'h104);
    step(1'b1, WB_NONE, 1'b1, 5'd7, 32'h55, 32'h66, 32'h77, LW, 1'b0, 32'd0, 1'b0);
    chk("none_data", wdata, 32'd0);

    // Flush while waiting; the late response must be ignored
    step(1'b1, WB_MEM, 1'b1, 5'd4, 32'd0, 32'd0, 32'd0, LW, 1'b0, 32'd0, 1'b0);
    idle(1'b0, 32'd0, 1'b1);
    idle(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("flush_no_we", 32'(rf_we), 32'd0);

    // Timeout after 16 wait cycles, cleared only by reset
    step(1'b1, WB_MEM, 1'b1, 5'd6, 32'd0, 32'd0, 32'd0, LW, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) idle(1'b0, 32'd0, 1'b0);
    chk("timeout_set", 32'(terr), 32'd1);
    idle(1'b0, 32'd0, 1'b0);
    chk("timeout_sticky", 32'(terr), 32'd1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 9) < 6, sels[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), r,
           $urandom(), $urandom(), $urandom(), loads[$urandom_range(0, 4)],
           $urandom_range(0, 9) < 3, $urandom(), $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
